// File: rtl/debug_unit.sv
// Host-side debug controller: decodes UART command bytes, gates the
// processor clock-enable for run / single-step / halt, and streams a
// snapshot of the debug bus out through the UART TX FIFO, MSB byte first.
module debug_unit #(
  parameter int         DBG_WIDTH = 10,
  parameter logic [7:0] CMD_RUN   = 8'h63,
  parameter logic [7:0] CMD_STEP  = 8'h73,
  parameter logic [7:0] CMD_DUMP  = 8'h64,
  parameter logic [7:0] CMD_HALT  = 8'h68
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DBG_WIDTH-1:0] debug_signal,
  input  logic [7:0]           r_data,
  input  logic                 rx_empty,
  output logic                 rd,
  input  logic                 tx_full,
  output logic [7:0]           w_data,
  output logic                 wr,
  output logic                 enable,
  output logic                 busy
);

  localparam int N_BYTES = (DBG_WIDTH + 7) / 8;
  localparam int PAD     = N_BYTES * 8 - DBG_WIDTH;
  localparam int SH_W    = N_BYTES * 8;
  localparam int CNT_W   = $clog2(N_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    SNAP = 3'd3,
    SEND = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [SH_W-1:0]    shreg_reg, shreg_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               enable_reg;

  // State, shift register, byte counter and the registered clock-enable.
  // enable follows the state being entered, so it is high exactly during
  // RUN and STEP cycles and drops on the cycle after HALT is popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      enable_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      cnt_reg    <= cnt_next;
      enable_reg <= (state_next == RUN) || (state_next == STEP);
    end
  end

  // Next-state and FIFO strobes; strobes are suppressed while reset is high
  // so a reset mid-dump never pushes another byte.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    rd         = 1'b0;
    wr         = 1'b0;
    w_data     = shreg_reg[SH_W-1 -: 8];
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          rd = !rx_empty;
          if (!rx_empty) begin
            if (r_data == CMD_RUN)       state_next = RUN;
            else if (r_data == CMD_STEP) state_next = STEP;
            else if (r_data == CMD_DUMP) state_next = SNAP;
          end
        end
        RUN: begin
          rd = !rx_empty;
          if (!rx_empty && (r_data == CMD_HALT)) state_next = SNAP;
        end
        STEP: begin
          state_next = SNAP;
        end
        SNAP: begin
          // Zero padding sits at the LSB end so the MSB byte goes out first.
          shreg_next = SH_W'(debug_signal) << PAD;
          cnt_next   = CNT_W'(N_BYTES);
          state_next = SEND;
        end
        SEND: begin
          wr = !tx_full;
          if (!tx_full) begin
            shreg_next = shreg_reg << 8;
            cnt_next   = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign enable = enable_reg;
  assign busy   = !reset && (state_reg != IDLE);

endmodule

// File: tb/tb_debug_unit.sv
// Directed self-checking bench for debug_unit with a behavioural RX/TX
// FIFO model and a stub pipeline counter that advances on enable.
module tb_debug_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] debug_signal;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr;
  logic       enable;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [9:0] stub_cnt;
  logic [9:0] dbg_const;
  logic       use_stub;
  int         rd_count;
  int         en_count;

  debug_unit dut (
    .clock        (clock),
    .reset        (reset),
    .debug_signal (debug_signal),
    .r_data       (r_data),
    .rx_empty     (rx_empty),
    .rd           (rd),
    .tx_full      (tx_full),
    .w_data       (w_data),
    .wr           (wr),
    .enable       (enable),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive_inputs();
    rx_empty     = (rx_q.size() == 0);
    r_data       = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    debug_signal = use_stub ? stub_cnt : dbg_const;
  endtask

  // One clock: sample strobes away from the edge, then apply the FIFO and
  // stub-counter model at the following falling edge.
  task automatic tick();
    logic rd_s, wr_s, en_s;
    logic [7:0] wd_s;
    drive_inputs();
    #1;
    rd_s = rd;
    wr_s = wr;
    en_s = enable;
    wd_s = w_data;
    @(posedge clock);
    @(negedge clock);
    if (rd_s && rx_q.size() > 0) void'(rx_q.pop_front());
    if (wr_s) tx_q.push_back(wd_s);
    if (en_s) begin
      stub_cnt = stub_cnt + 10'd1;
      en_count++;
    end
    if (rd_s) rd_count++;
    drive_inputs();
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    tick();
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [7:0] tx_at(input int i);
    return (tx_q.size() > i) ? tx_q[i] : 8'hxx;
  endfunction

  task automatic clear_stats();
    tx_q.delete();
    rd_count = 0;
    en_count = 0;
  endtask

  initial begin
    reset     = 1'b1;
    tx_full   = 1'b0;
    use_stub  = 1'b0;
    dbg_const = 10'h000;
    stub_cnt  = 10'd0;
    rd_count  = 0;
    en_count  = 0;
    rx_q.push_back(8'h00);
    drive_inputs();
    @(negedge clock);

    // 1: reset with a non-empty RX FIFO
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd",     {31'd0, rd},     32'd0);
      check("rst_wr",     {31'd0, wr},     32'd0);
      check("rst_enable", {31'd0, enable}, 32'd0);
      check("rst_busy",   {31'd0, busy},   32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_rx_drained", rx_q.size(), 32'd0);

    // 2: dump of 10'h2A5
    clear_stats();
    dbg_const = 10'h2A5;
    rx_q.push_back(8'h64);
    wait_idle(50);
    check("dump_nbytes", tx_q.size(), 32'd2);
    check("dump_b0", {24'd0, tx_at(0)}, 32'hA9);
    check("dump_b1", {24'd0, tx_at(1)}, 32'h40);
    check("dump_enable_cycles", en_count, 32'd0);
    check("dump_rd_pops", rd_count, 32'd1);

    // 3: single step from counter 5
    clear_stats();
    use_stub = 1'b1;
    stub_cnt = 10'd5;
    rx_q.push_back(8'h73);
    wait_idle(50);
    check("step_enable_cycles", en_count, 32'd1);
    check("step_nbytes", tx_q.size(), 32'd2);
    check("step_b0", {24'd0, tx_at(0)}, 32'h01);
    check("step_b1", {24'd0, tx_at(1)}, 32'h80);

    // 4: run for 20 cycles, then halt
    clear_stats();
    rx_q.push_back(8'h63);
    for (int i = 0; i < 20; i++) tick();
    check("run_enable_high", {31'd0, enable}, 32'd1);
    rx_q.push_back(8'h68);
    tick();
    check("halt_enable_low", {31'd0, enable}, 32'd0);
    check("halt_busy", {31'd0, busy}, 32'd1);
    wait_idle(50);
    check("run_enable_cycles", en_count, 32'd20);
    check("run_nbytes", tx_q.size(), 32'd2);
    check("run_b0", {24'd0, tx_at(0)}, 32'h06);
    check("run_b1", {24'd0, tx_at(1)}, 32'h80);

    // 5: TX back-pressure before the second byte
    clear_stats();
    use_stub = 1'b0;
    rx_q.push_back(8'h64);
    tick();
    tick();
    tick();
    check("bp_first_byte", tx_q.size(), 32'd1);
    tx_full = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_wr_low", {31'd0, wr}, 32'd0);
      check("bp_wdata_held", {24'd0, w_data}, 32'h40);
      tick();
    end
    tx_full = 1'b0;
    wait_idle(50);
    check("bp_nbytes", tx_q.size(), 32'd2);
    check("bp_b0", {24'd0, tx_at(0)}, 32'hA9);
    check("bp_b1", {24'd0, tx_at(1)}, 32'h40);

    // 6: unknown byte ignored, then reset mid-dump
    clear_stats();
    rx_q.push_back(8'h78);
    tick();
    check("unk_consumed", rx_q.size(), 32'd0);
    check("unk_busy", {31'd0, busy}, 32'd0);
    check("unk_no_tx", tx_q.size(), 32'd0);
    rx_q.push_back(8'h64);
    tick();
    tick();
    tick();
    check("abort_first_byte", {24'd0, tx_at(0)}, 32'hA9);
    reset = 1'b1;
    #1;
    check("abort_wr_in_reset", {31'd0, wr}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_nbytes", tx_q.size(), 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wdata", {24'd0, w_data}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
